// File: rtl/flit_rx_assembler_pkg.sv
// ---------------------------------------------------------------------------
// Package types
// Shared definitions for the flit receive assembler:
//   FLIT_BYTES_DEFAULT : default number of bytes per flit (last byte = checksum)
//   flit_t             : one assembled flit, byte 0 in the most significant byte
//   state_t            : assembler FSM states (IDLE, COLLECT, HOLD)
// ---------------------------------------------------------------------------
package types;

  localparam int FLIT_BYTES_DEFAULT = 8;

  typedef logic [8*FLIT_BYTES_DEFAULT-1:0] flit_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

endpackage

// File: rtl/flit_checksum_xor.sv
// ---------------------------------------------------------------------------
// flit_checksum_xor
// Combinational XOR of the payload bytes of a flit (bytes 0..FLIT_BYTES-2).
// Only instantiated when FLIT_RX_CHECKSUM_EN is defined.
// Ports:
//   i_payload : bytes 0..FLIT_BYTES-2, byte 0 in the most significant byte
//   o_xor     : XOR of all payload bytes
// ---------------------------------------------------------------------------
module flit_checksum_xor
  import types::*;
#(
  parameter int FLIT_BYTES = FLIT_BYTES_DEFAULT
) (
  input  logic [8*(FLIT_BYTES-1)-1:0] i_payload,
  output logic [7:0]                  o_xor
);

  always_comb begin
    o_xor = 8'h00;
    for (int i = 0; i < FLIT_BYTES - 1; i++) begin
      o_xor = o_xor ^ i_payload[8*(FLIT_BYTES-1-i)-1 -: 8];
    end
  end

endmodule

// File: rtl/flit_rx_assembler.sv
// ---------------------------------------------------------------------------
// flit_rx_assembler
// Collects a byte stream into FLIT_BYTES-byte flits (MSB first), optionally
// verifies the trailing XOR checksum, and holds each completed flit until the
// downstream controller accepts it. Partial flits that stall for
// TIMEOUT_CYCLES idle cycles are discarded.
//
// Build option: define FLIT_RX_CHECKSUM_EN to enable checksum checking.
// Without it every complete flit is delivered and checksum_error stays 0.
//
// Ports:
//   nocclk              : clock
//   rst                 : synchronous active-high reset
//   rx_byte             : incoming byte
//   rx_byte_valid       : incoming byte present
//   rx_byte_ready       : byte accepted when high together with valid
//   received_flit       : assembled flit (meaningful only while valid)
//   received_flit_valid : flit present
//   received_flit_ready : downstream accepts the flit
//   checksum_error      : one-cycle pulse, flit dropped on bad checksum
//   timeout_error       : one-cycle pulse, partial flit dropped on stall
//   drop_count          : saturating count of dropped flits
// ---------------------------------------------------------------------------
module flit_rx_assembler
  import types::*;
#(
  parameter int FLIT_BYTES     = FLIT_BYTES_DEFAULT,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       nocclk,
  input  logic       rst,
  input  logic [7:0] rx_byte,
  input  logic       rx_byte_valid,
  output logic       rx_byte_ready,
  output flit_t      received_flit,
  output logic       received_flit_valid,
  input  logic       received_flit_ready,
  output logic       checksum_error,
  output logic       timeout_error,
  output logic [7:0] drop_count
);

  localparam int IDX_W = $clog2(FLIT_BYTES);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  state_t                  r_state, w_state_next;
  logic [IDX_W-1:0]        r_idx, w_idx_next;
  logic [TO_W-1:0]         r_idle, w_idle_next;
  logic [8*FLIT_BYTES-1:0] r_asm, w_asm_next;
  flit_t                   r_flit, w_flit_next;
  logic                    r_ready, w_ready_next;
  logic                    r_cerr, w_cerr_next;
  logic                    r_terr, w_terr_next;
  logic [7:0]              r_drops, w_drops_next;
  logic                    w_accept;
  logic                    w_last;
  logic                    w_drop;
  logic                    w_cksum_ok;

`ifdef FLIT_RX_CHECKSUM_EN
  logic [7:0] w_xor;

  // Payload bytes are already in r_asm when the checksum byte arrives.
  flit_checksum_xor #(
    .FLIT_BYTES (FLIT_BYTES)
  ) u_checksum (
    .i_payload (r_asm[8*FLIT_BYTES-1:8]),
    .o_xor     (w_xor)
  );

  assign w_cksum_ok = (w_xor == rx_byte);
`else
  // Checksum always accepted; r_cerr therefore folds to a constant 0.
  assign w_cksum_ok = 1'b1;
`endif

  assign w_accept = rx_byte_valid && r_ready;
  assign w_last   = (r_idx == IDX_W'(FLIT_BYTES - 1));

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_idle_next  = r_idle;
    w_asm_next   = r_asm;
    w_flit_next  = r_flit;
    w_cerr_next  = 1'b0;
    w_terr_next  = 1'b0;
    w_drop       = 1'b0;

    case (r_state)
      IDLE: begin
        w_idx_next  = '0;
        w_idle_next = '0;
        if (w_accept) begin
          w_asm_next[8*FLIT_BYTES-1 -: 8] = rx_byte;
          w_idx_next   = IDX_W'(1);
          w_state_next = COLLECT;
        end
      end

      COLLECT: begin
        if (w_accept) begin
          // An accept always clears the idle counter, so it can never time out
          // in the same cycle.
          w_idle_next = '0;
          w_asm_next[8*(FLIT_BYTES-int'(r_idx))-1 -: 8] = rx_byte;
          if (w_last) begin
            w_idx_next = '0;
            if (w_cksum_ok) begin
              w_flit_next  = {r_asm[8*FLIT_BYTES-1:8], rx_byte};
              w_state_next = HOLD;
            end else begin
              w_cerr_next  = 1'b1;
              w_drop       = 1'b1;
              w_state_next = IDLE;
            end
          end else begin
            w_idx_next = r_idx + IDX_W'(1);
          end
        end else if (r_idle == TO_W'(TIMEOUT_CYCLES - 1)) begin
          // This idle cycle brings the count to TIMEOUT_CYCLES.
          w_terr_next  = 1'b1;
          w_drop       = 1'b1;
          w_idx_next   = '0;
          w_idle_next  = '0;
          w_state_next = IDLE;
        end else begin
          w_idle_next = r_idle + TO_W'(1);
        end
      end

      HOLD: begin
        if (received_flit_ready) begin
          w_state_next = IDLE;
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase

    // Registered so it is low during reset and never overlaps HOLD.
    w_ready_next = (w_state_next != HOLD);

    w_drops_next = r_drops;
    if (w_drop && (r_drops != 8'hFF)) begin
      w_drops_next = r_drops + 8'd1;
    end
  end

  always_ff @(posedge nocclk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_idle  <= '0;
      r_asm   <= '0;
      r_flit  <= '0;
      r_ready <= 1'b0;
      r_cerr  <= 1'b0;
      r_terr  <= 1'b0;
      r_drops <= 8'h00;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_idle  <= w_idle_next;
      r_asm   <= w_asm_next;
      r_flit  <= w_flit_next;
      r_ready <= w_ready_next;
      r_cerr  <= w_cerr_next;
      r_terr  <= w_terr_next;
      r_drops <= w_drops_next;
    end
  end

  assign rx_byte_ready       = r_ready;
  assign received_flit       = r_flit;
  assign received_flit_valid = (r_state == HOLD);
  assign checksum_error      = r_cerr;
  assign timeout_error       = r_terr;
  assign drop_count          = r_drops;

endmodule

// File: doc/flit_rx_assembler.md
FLIT_RX_ASSEMBLER -- requirements
Module: flit_rx_assembler

Interface
REQ-001 Parameter FLIT_BYTES, default 8, bytes per flit; the last byte is the checksum byte.
REQ-002 Parameter TIMEOUT_CYCLES, default 255, idle cycles allowed inside a partial flit before it is discarded.
REQ-003 Clocking and reset SHALL be one clock, `nocclk`, and one synchronous active-high reset, `rst`.
REQ-004 Ports SHALL be:
- `nocclk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `rx_byte`  in  8  inter-device byte.
- `rx_byte_valid`  in  1  byte present.
- `rx_byte_ready`  out  1  byte accepted when high with valid.
- `received_flit`  out  types::flit_t (8*FLIT_BYTES)  assembled flit.
- `received_flit_valid`  out  1  flit present.
- `received_flit_ready`  in  1  downstream receive controller accepts.
- `checksum_error`  out  1  one-cycle pulse, flit dropped.
- `timeout_error`  out  1  one-cycle pulse, partial flit dropped.
- `drop_count`  out  8  saturating count of dropped flits.

Function
REQ-005 The FSM SHALL have exactly three states: IDLE, COLLECT and HOLD.
REQ-006 `rx_byte_ready` SHALL be 1 in IDLE and COLLECT and 0 in HOLD.
REQ-007 A byte is accepted on a cycle where `rx_byte_valid` and `rx_byte_ready` are both high.
- An accept in IDLE stores byte 0 and moves to COLLECT.
- Byte index i SHALL be stored at flit bits [8*(FLIT_BYTES-i)-1 -: 8], i.e. MSB first.
REQ-008 The byte index counter SHALL be $clog2(FLIT_BYTES) bits wide and SHALL be cleared on every return to IDLE.
REQ-009 On accepting byte FLIT_BYTES-1 with a good checksum, the block SHALL enter HOLD.
- `received_flit_valid` rises the next cycle, so latency is 1 cycle from the last byte accepted.
REQ-010 The checksum is good when byte FLIT_BYTES-1 equals the XOR of bytes 0..FLIT_BYTES-2.
- On mismatch: pulse `checksum_error` the next cycle, increment `drop_count`, go to IDLE, never assert valid.
REQ-011 In HOLD, `received_flit` and `received_flit_valid` SHALL stay stable until `received_flit_ready` is high.
- On that handshake cycle the state SHALL go to IDLE, and valid SHALL be 0 the following cycle.
REQ-012 An idle counter SHALL run in COLLECT.
- It increments on each cycle with no byte accepted.
- It clears on each accepted byte.
- When it reaches TIMEOUT_CYCLES: pulse `timeout_error` next cycle, increment `drop_count`, discard the partial flit, go to IDLE.
REQ-013 An accept and a timeout SHALL never occur in the same cycle: an accepted byte clears the counter first.
REQ-014 `drop_count` SHALL saturate at 255 and never wrap.
REQ-015 `received_flit` SHALL hold its last value when valid is low; downstream must not sample it then.

Reset
REQ-016 While `rst` is high on a clock edge, the following SHALL hold the next cycle:
- state = IDLE;
- the byte index and idle counters are cleared;
- `rx_byte_ready`=0, `received_flit`=0, `received_flit_valid`=0, `checksum_error`=0, `timeout_error`=0, `drop_count`=0.
REQ-017 `rx_byte_ready` SHALL rise on the first cycle after `rst` deasserts.
REQ-018 A reset asserted mid-COLLECT or during HOLD SHALL discard the flit without any error pulse or count.

Configuration
REQ-019 With `FLIT_RX_CHECKSUM_EN` defined, checksum checking per REQ-010 SHALL be active.
REQ-020 Without `FLIT_RX_CHECKSUM_EN`, every complete flit SHALL go to HOLD regardless of the last byte.
- The last byte is still stored in the flit.
- `checksum_error` SHALL be tied to 0.

Structure
REQ-021 Package `types` SHALL hold `flit_t`, the FLIT_BYTES default constant and the FSM state enum.
REQ-022 XOR checksum computation SHALL be a sub-module, `flit_checksum_xor`: combinational, FLIT_BYTES-parameterised, instantiated only under `FLIT_RX_CHECKSUM_EN`.

Verification
REQ-023 Good flit: send bytes 01 02 03 04 05 06 07 00 back-to-back with ready held at 1.
- Required: valid 1 cycle after the last byte, flit=0x0102030405060700, no error.
REQ-024 Bad checksum: send 01 02 03 04 05 06 07 FF.
- Required: one-cycle `checksum_error`, `drop_count`=1, valid never high.
- Without the macro: flit=0x01020304050607FF delivered.
REQ-025 Backpressure: hold `received_flit_ready` at 0 for 20 cycles after a good flit.
- Required: flit and valid stable, `rx_byte_ready`=0 throughout.
- Handshake on cycle 21; `rx_byte_ready`=1 the following cycle.
REQ-026 Timeout: with TIMEOUT_CYCLES=4, send 3 bytes and then stall.
- Required: `timeout_error` pulse after 4 idle cycles, `drop_count`=1.
- The next 8 good bytes assemble into a correct flit.
REQ-027 Reset and saturation:
- Assert `rst` after byte 5; required: no error pulse, and the next full flit is correct.
- Force 300 bad flits; required: `drop_count`=255.
